// File: rtl/box_sprite_engine.sv
// rtl/box_sprite_engine.sv - box sprite draw/erase/move engine feeding a 160x120 VGA adapter
//
// Animates one box (the head) by STEP pixels per animation tick in a latched
// direction, redraws a static box (the apple) every frame and pulses hit when
// the head lands on the apple. One pixel per cycle is emitted towards the
// VGA adapter.
//
// Ports:
//   Clock, Resetn        clock, asynchronous active-low reset
//   init                 synchronous reload of head position/direction, FSM to IDLE
//   go                   level, leave IDLE on the next tick
//   dir_valid, dir       direction strobe (00 right, 01 down, 10 up, 11 left)
//   colour               head colour
//   apple_x/y, apple_colour  apple top-left corner and colour
//   vga_x/y, vga_colour, plot  registered pixel stream
//   head_x/y             current head position
//   hit                  one-cycle pulse after a move that overlaps the apple
//   busy                 high while drawing, erasing or moving

module box_sprite_engine #(
    parameter int         XSCREEN = 160,
    parameter int         YSCREEN = 120,
    parameter int         XDIM    = 10,
    parameter int         YDIM    = 10,
    parameter int         STEP    = 1,
    parameter int         K       = 20,
    parameter int         WRAP    = 0,
    parameter int         X0      = 39,
    parameter int         Y0      = 59,
    parameter logic [2:0] BG      = 3'b000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       init,
    input  logic       go,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic [2:0] colour,
    input  logic [7:0] apple_x,
    input  logic [6:0] apple_y,
    input  logic [2:0] apple_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic [7:0] head_x,
    output logic [6:0] head_y,
    output logic       hit,
    output logic       busy
);

    localparam int XW   = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int YW   = (YDIM > 1) ? $clog2(YDIM) : 1;
    localparam int XMAX = XSCREEN - XDIM;
    localparam int YMAX = YSCREEN - YDIM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW_H,
        S_DRAW_A,
        S_WAIT,
        S_ERASE_H,
        S_MOVE
    } state_t;

    state_t        state;
    logic [K-1:0]  tick_cnt;
    logic [XW-1:0] xc;
    logic [YW-1:0] yc;
    logic [1:0]    cur_dir;
    logic          dir_on;

    logic       tick;
    logic       last_px;
    logic       row_end;
    logic [7:0] hx_px;
    logic [6:0] hy_px;
    logic [8:0] ax_px;
    logic [7:0] ay_px;
    logic [8:0] x_ext, x_inc, ax_ext;
    logic [7:0] y_ext, y_inc, ay_ext;
    logic [8:0] nx;
    logic [7:0] ny;
    logic       hit_next;
    logic       dir_ok;

    assign tick    = (tick_cnt == '0);
    assign row_end = (xc == XW'(XDIM - 1));
    assign last_px = row_end && (yc == YW'(YDIM - 1));

    // The head never reaches past the screen edge, so its pixel sums fit the
    // VGA coordinate widths; the apple can, so its sums keep a carry bit.
    assign hx_px = head_x + 8'(xc);
    assign hy_px = head_y + 7'(yc);
    assign ax_px = {1'b0, apple_x} + 9'(xc);
    assign ay_px = {1'b0, apple_y} + 8'(yc);

    assign x_ext  = {1'b0, head_x};
    assign y_ext  = {1'b0, head_y};
    assign x_inc  = x_ext + 9'(STEP);
    assign y_inc  = y_ext + 8'(STEP);
    assign ax_ext = {1'b0, apple_x};
    assign ay_ext = {1'b0, apple_y};

    always_comb begin
        nx = x_ext;
        ny = y_ext;
        if (dir_on) begin
            case (cur_dir)
                2'b00: nx = (x_inc > 9'(XMAX)) ? ((WRAP != 0) ? 9'd0 : 9'(XMAX)) : x_inc;
                2'b11: nx = (x_ext < 9'(STEP)) ? ((WRAP != 0) ? 9'(XMAX) : 9'd0) : x_ext - 9'(STEP);
                2'b01: ny = (y_inc > 8'(YMAX)) ? ((WRAP != 0) ? 8'd0 : 8'(YMAX)) : y_inc;
                default: ny = (y_ext < 8'(STEP)) ? ((WRAP != 0) ? 8'(YMAX) : 8'd0) : y_ext - 8'(STEP);
            endcase
        end
    end

    assign hit_next = (nx < ax_ext + 9'(XDIM)) && (ax_ext < nx + 9'(XDIM)) &&
                      (ny < ay_ext + 8'(YDIM)) && (ay_ext < ny + 8'(YDIM));

    // The direction encoding puts opposite directions at bitwise complements,
    // so an exact reversal is dir == ~cur_dir.
    assign dir_ok = !dir_on || (dir != ~cur_dir);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            xc         <= '0;
            yc         <= '0;
            cur_dir    <= 2'b00;
            dir_on     <= 1'b0;
            head_x     <= 8'(X0);
            head_y     <= 7'(Y0);
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            hit        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Free-running: the animation rate is independent of the FSM.
            tick_cnt <= tick_cnt + 1'b1;
            if (init) begin
                state   <= S_IDLE;
                xc      <= '0;
                yc      <= '0;
                cur_dir <= 2'b00;
                dir_on  <= 1'b0;
                head_x  <= 8'(X0);
                head_y  <= 7'(Y0);
                plot    <= 1'b0;
                hit     <= 1'b0;
                busy    <= 1'b0;
            end else begin
                if (dir_valid && dir_ok) begin
                    cur_dir <= dir;
                    dir_on  <= 1'b1;
                end
                plot <= 1'b0;
                hit  <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (go && tick) begin
                            state <= S_DRAW_H;
                            busy  <= 1'b1;
                        end
                    end
                    S_DRAW_H, S_DRAW_A, S_ERASE_H: begin
                        if (state == S_DRAW_A) begin
                            vga_x      <= ax_px[7:0];
                            vga_y      <= ay_px[6:0];
                            vga_colour <= apple_colour;
                            plot       <= (ax_px < 9'(XSCREEN)) && (ay_px < 8'(YSCREEN));
                        end else begin
                            vga_x      <= hx_px;
                            vga_y      <= hy_px;
                            vga_colour <= (state == S_DRAW_H) ? colour : BG;
                            plot       <= 1'b1;
                        end
                        if (last_px) begin
                            xc <= '0;
                            yc <= '0;
                            case (state)
                                S_DRAW_H: state <= S_DRAW_A;
                                S_DRAW_A: begin
                                    state <= S_WAIT;
                                    busy  <= 1'b0;
                                end
                                default:  state <= S_MOVE;
                            endcase
                        end else if (row_end) begin
                            xc <= '0;
                            yc <= yc + 1'b1;
                        end else begin
                            xc <= xc + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (tick) begin
                            state <= S_ERASE_H;
                            busy  <= 1'b1;
                        end
                    end
                    S_MOVE: begin
                        head_x <= nx[7:0];
                        head_y <= ny[6:0];
                        hit    <= hit_next;
                        state  <= S_DRAW_H;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
